// File: rtl/cpu_ctrl_pkg.sv
// Shared control-path definitions: op encodings, CMP condition codes and the
// branch controller state enum.
package cpu_ctrl_pkg;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JCC  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  localparam logic [3:0] CC_EQ   = 4'b0000;
  localparam logic [3:0] CC_NE   = 4'b0001;
  localparam logic [3:0] CC_GT   = 4'b0010;
  localparam logic [3:0] CC_LT   = 4'b0011;
  localparam logic [3:0] CC_ZERO = 4'b0100;
  localparam logic [3:0] CC_NEG  = 4'b0101;
  localparam logic [3:0] CC_ONES = 4'b0110;
  // Negated variants; 4'b0111 and 4'b11xx are undefined and CMP answers 0.
  localparam logic [3:0] CC_N0   = 4'b1000;
  localparam logic [3:0] CC_N1   = 4'b1001;
  localparam logic [3:0] CC_N2   = 4'b1010;
  localparam logic [3:0] CC_N3   = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_EVAL   = 2'b01,
    ST_COMMIT = 2'b10
  } bc_state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address LIFO. A push when full overwrites the oldest entry;
// a pop when empty does nothing. Overflow/underflow are same-cycle pulses.
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         overflow_o,
  output logic         underflow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] ptr_q;
  logic [PW:0]   cnt_q;
  logic [PW-1:0] top_idx;

  assign top_idx     = ptr_q - 1'b1;
  assign pop_data_o  = mem_q[top_idx];
  assign full_o      = (cnt_q == FULL_CNT);
  assign empty_o     = (cnt_q == '0);
  assign overflow_o  = push_i & full_o;
  assign underflow_o = pop_i & ~push_i & empty_o;

  // The write pointer always advances on push, so when full it lands on the
  // oldest slot and overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else if (push_i) begin
      ptr_q <= ptr_q + 1'b1;
      if (!full_o) cnt_q <= cnt_q + 1'b1;
    end else if (pop_i && !empty_o) begin
      ptr_q <= top_idx;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/branch_controller.sv
// Program-counter sequencer: accepts one control-flow op, consults CMP for one
// cycle, then offers the committed PC to fetch over valid/ready.
module branch_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [1:0]      op,
  input  logic [3:0]      cond,
  input  logic [PC_W-1:0] target,
  output logic [3:0]      cmp_cond,
  input  logic            cmp_jump,
  output logic [PC_W-1:0] pc,
  output logic            pc_valid,
  input  logic            fetch_ready,
  output logic            flush,
  output logic            ras_err,
  output logic [1:0]      state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // instr_ready is high only in IDLE; pc_valid stays high with pc/flush stable
  // until fetch_ready is seen.

  bc_state_e       state_q, state_d;
  logic [1:0]      op_q;
  logic [3:0]      cmp_cond_q;
  logic [PC_W-1:0] target_q, pc_q, pc_d, pc_inc;
  logic            flush_q, flush_d, ras_err_q;
  logic            in_eval, accept, ras_push, ras_pop;
  logic            ras_empty, ras_full, ras_ovf, ras_unf;
  logic [PC_W-1:0] ras_top;

  assign in_eval     = (state_q == ST_EVAL);
  assign accept      = (state_q == ST_IDLE) && instr_valid;
  assign pc_inc      = pc_q + 1'b1;
  assign ras_push    = in_eval && (op_q == OP_CALL);
  assign ras_pop     = in_eval && (op_q == OP_RET);

  assign instr_ready = (state_q == ST_IDLE);
  assign pc_valid    = (state_q == ST_COMMIT);
  assign flush       = flush_q;
  assign pc          = pc_q;
  assign cmp_cond    = cmp_cond_q;
  assign ras_err     = ras_err_q;
  assign state_dbg   = state_q;

  ras_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_inc),
    .pop_data_o  (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .overflow_o  (ras_ovf),
    .underflow_o (ras_unf)
  );

  always_comb begin
    pc_d    = pc_inc;
    flush_d = 1'b0;
    case (op_q)
      OP_JCC:  if (cmp_jump) begin pc_d = target_q; flush_d = 1'b1; end
      OP_CALL: begin pc_d = target_q; flush_d = 1'b1; end
      OP_RET:  if (!ras_empty) begin pc_d = ras_top; flush_d = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_EVAL;
      ST_EVAL:   state_d = ST_COMMIT;
      ST_COMMIT: if (fetch_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_SEQ;
      cmp_cond_q <= 4'b0000;
      target_q   <= '0;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      ras_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= op;
        cmp_cond_q <= cond;
        target_q   <= target;
      end
      if (in_eval) begin
        pc_q      <= pc_d;
        flush_q   <= flush_d;
        ras_err_q <= ras_err_q | ras_ovf | ras_unf;
      end
      if ((state_q == ST_COMMIT) && fetch_ready) flush_q <= 1'b0;
    end
  end

  logic unused_full;
  assign unused_full = ras_full;

endmodule

// File: tb/tb_branch_controller.sv
// Bench for branch_controller: directed scenarios plus randomized op streams
// checked against a queue-based model of PC sequencing and the return stack.
module tb_branch_controller;

  localparam logic [15:0] RST_PC = 16'hFFFF;

  logic        clk, rst_n;
  logic        instr_valid, instr_ready;
  logic [1:0]  op;
  logic [3:0]  cond, cmp_cond;
  logic [15:0] target, pc;
  logic        cmp_jump, pc_valid, fetch_ready, flush, ras_err;
  logic [1:0]  state_dbg;

  branch_controller #(.PC_W(16), .RAS_DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .cond(cond), .target(target), .cmp_cond(cmp_cond), .cmp_jump(cmp_jump),
    .pc(pc), .pc_valid(pc_valid), .fetch_ready(fetch_ready), .flush(flush),
    .ras_err(ras_err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [15:0] exp_pc;
  logic        exp_flush, exp_err;
  logic [15:0] ras_q[$];

  task automatic model_reset();
    exp_pc = RST_PC; exp_flush = 1'b0; exp_err = 1'b0;
    ras_q.delete();
  endtask

  task automatic model_step(input logic [1:0] o, input logic [15:0] t, input logic j);
    logic [15:0] nxt;
    nxt = exp_pc + 16'd1;
    exp_flush = 1'b0;
    case (o)
      2'b00: exp_pc = nxt;
      2'b01: begin exp_pc = j ? t : nxt; exp_flush = j; end
      2'b10: begin
        if (ras_q.size() == 4) begin void'(ras_q.pop_front()); exp_err = 1'b1; end
        ras_q.push_back(nxt);
        exp_pc = t; exp_flush = 1'b1;
      end
      default: begin
        if (ras_q.size() > 0) begin exp_pc = ras_q.pop_back(); exp_flush = 1'b1; end
        else begin exp_pc = nxt; exp_err = 1'b1; end
      end
    endcase
  endtask

  // ---------------- driver ----------------
  logic [3:0]  obs_eval_cond;
  logic        obs_eval_valid, obs_eval_ready;
  logic [15:0] obs_pc;
  logic        obs_flush, obs_valid, obs_err, obs_commit_ready;
  logic        obs_stall_ok, obs_after_valid, obs_after_ready, obs_after_flush;

  task automatic do_reset();
    rst_n = 1'b0; instr_valid = 1'b0; op = 2'b00; cond = 4'h0; target = '0;
    cmp_jump = 1'b0; fetch_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  // Starts and ends on a negedge; records observations at each phase.
  task automatic do_instr(input logic [1:0] o, input logic [3:0] c,
                          input logic [15:0] t, input logic j, input int stall);
    int w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) begin
      n_checks++;
      $display("FAIL accept_timeout: instr_ready got 0 exp 1 within 20 cycles");
    end
    instr_valid = 1'b1; op = o; cond = c; target = t; cmp_jump = j;
    fetch_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0; op = $urandom_range(0, 3); target = $urandom;
    obs_eval_cond = cmp_cond; obs_eval_valid = pc_valid; obs_eval_ready = instr_ready;
    @(posedge clk);
    @(negedge clk);
    cmp_jump = $urandom_range(0, 1);
    obs_pc = pc; obs_flush = flush; obs_valid = pc_valid; obs_err = ras_err;
    obs_commit_ready = instr_ready;
    obs_stall_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (pc !== obs_pc || flush !== obs_flush || pc_valid !== 1'b1 ||
          instr_ready !== 1'b0 || cmp_cond !== c) obs_stall_ok = 1'b0;
      if (i == stall - 1) fetch_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    obs_after_valid = pc_valid; obs_after_ready = instr_ready; obs_after_flush = flush;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b1; op = 2'b10; cond = 4'h3; target = 16'h1234;
    cmp_jump = 1'b1; fetch_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h exp %h", pc, RST_PC); else n_pass++;
    n_checks++; if (pc_valid !== 1'b0 || flush !== 1'b0) $display("FAIL reset_valid_flush: got %b%b exp 00", pc_valid, flush); else n_pass++;
    n_checks++; if (cmp_cond !== 4'b0000) $display("FAIL reset_cmp_cond: got %b exp 0000", cmp_cond); else n_pass++;
    n_checks++; if (ras_err !== 1'b0 || instr_ready !== 1'b1) $display("FAIL reset_err_ready: got %b%b exp 01", ras_err, instr_ready); else n_pass++;
    instr_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
  endtask

  task automatic test_seq_wrap();
    do_reset();
    do_instr(2'b00, 4'h0, 16'h0, 1'b0, 0); model_step(2'b00, 16'h0, 1'b0);
    n_checks++; if (obs_pc !== 16'h0000 || obs_flush !== 1'b0) $display("FAIL seq1: got pc %h flush %b exp 0000/0", obs_pc, obs_flush); else n_pass++;
    n_checks++; if (obs_eval_valid !== 1'b0 || obs_valid !== 1'b1 || obs_after_valid !== 1'b0) $display("FAIL seq1_valid: got %b%b%b exp 010", obs_eval_valid, obs_valid, obs_after_valid); else n_pass++;
    n_checks++; if (obs_eval_ready !== 1'b0 || obs_commit_ready !== 1'b0) $display("FAIL seq1_ready: got %b%b exp 00", obs_eval_ready, obs_commit_ready); else n_pass++;
    do_instr(2'b00, 4'h0, 16'h0, 1'b0, 0); model_step(2'b00, 16'h0, 1'b0);
    n_checks++; if (obs_pc !== 16'h0001 || obs_flush !== 1'b0) $display("FAIL seq2: got pc %h flush %b exp 0001/0", obs_pc, obs_flush); else n_pass++;
  endtask

  task automatic test_jcc();
    do_instr(2'b01, 4'h0, 16'h0010, 1'b1, 0); model_step(2'b01, 16'h0010, 1'b1);
    do_instr(2'b01, 4'b0000, 16'h0100, 1'b1, 0); model_step(2'b01, 16'h0100, 1'b1);
    n_checks++; if (obs_pc !== 16'h0100 || obs_flush !== 1'b1) $display("FAIL jcc_taken: got pc %h flush %b exp 0100/1", obs_pc, obs_flush); else n_pass++;
    n_checks++; if (obs_eval_cond !== 4'b0000) $display("FAIL jcc_cmp_cond: got %b exp 0000", obs_eval_cond); else n_pass++;
    do_instr(2'b01, 4'b0000, 16'h0100, 1'b0, 0); model_step(2'b01, 16'h0100, 1'b0);
    n_checks++; if (obs_pc !== 16'h0101 || obs_flush !== 1'b0) $display("FAIL jcc_not_taken: got pc %h flush %b exp 0101/0", obs_pc, obs_flush); else n_pass++;
    do_instr(2'b01, 4'b1100, 16'h0777, 1'b1, 0); model_step(2'b01, 16'h0777, 1'b1);
    n_checks++; if (obs_eval_cond !== 4'b1100 || obs_pc !== exp_pc) $display("FAIL jcc_cond_c: got %b/%h exp 1100/%h", obs_eval_cond, obs_pc, exp_pc); else n_pass++;
  endtask

  task automatic test_call_ret();
    do_instr(2'b01, 4'h0, 16'h0020, 1'b1, 0); model_step(2'b01, 16'h0020, 1'b1);
    do_instr(2'b10, 4'h0, 16'h0200, 1'b0, 0); model_step(2'b10, 16'h0200, 1'b0);
    n_checks++; if (obs_pc !== 16'h0200 || obs_flush !== 1'b1) $display("FAIL call: got pc %h flush %b exp 0200/1", obs_pc, obs_flush); else n_pass++;
    do_instr(2'b11, 4'h0, 16'h0, 1'b0, 0); model_step(2'b11, 16'h0, 1'b0);
    n_checks++; if (obs_pc !== 16'h0021 || obs_flush !== 1'b1 || obs_err !== 1'b0) $display("FAIL ret: got pc %h flush %b err %b exp 0021/1/0", obs_pc, obs_flush, obs_err); else n_pass++;
  endtask

  task automatic test_ras_overflow();
    logic [15:0] base [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      base[i] = 16'h1000 + 16'(i * 16'h0111);
      do_instr(2'b01, 4'h0, base[i], 1'b1, 0); model_step(2'b01, base[i], 1'b1);
      do_instr(2'b10, 4'h0, 16'h4000 + 16'(i), 1'b0, 0); model_step(2'b10, 16'h4000 + 16'(i), 1'b0);
      n_checks++; if (obs_err !== (i == 4)) $display("FAIL ovf_err_%0d: got %b exp %b", i, obs_err, (i == 4)); else n_pass++;
    end
    for (int i = 4; i >= 1; i--) begin
      do_instr(2'b11, 4'h0, 16'h0, 1'b0, 0); model_step(2'b11, 16'h0, 1'b0);
      n_checks++; if (obs_pc !== base[i] + 16'd1 || obs_flush !== 1'b1) $display("FAIL ovf_ret_%0d: got pc %h flush %b exp %h/1", i, obs_pc, obs_flush, base[i] + 16'd1); else n_pass++;
    end
    do_instr(2'b11, 4'h0, 16'h0, 1'b0, 0);
    n_checks++; if (obs_pc !== base[1] + 16'd2 || obs_flush !== 1'b0 || obs_err !== 1'b1) $display("FAIL underflow: got pc %h flush %b err %b exp %h/0/1", obs_pc, obs_flush, obs_err, base[1] + 16'd2); else n_pass++;
    model_step(2'b11, 16'h0, 1'b0);
  endtask

  task automatic test_fetch_stall();
    do_instr(2'b01, 4'h2, 16'h0abc, 1'b1, 4); model_step(2'b01, 16'h0abc, 1'b1);
    n_checks++; if (obs_pc !== 16'h0abc || obs_flush !== 1'b1) $display("FAIL stall_pc: got pc %h flush %b exp 0abc/1", obs_pc, obs_flush); else n_pass++;
    n_checks++; if (obs_stall_ok !== 1'b1) $display("FAIL stall_stable: got %b exp 1", obs_stall_ok); else n_pass++;
    n_checks++; if (obs_after_valid !== 1'b0 || obs_after_flush !== 1'b0 || obs_after_ready !== 1'b1) $display("FAIL stall_release: got %b%b%b exp 001", obs_after_valid, obs_after_flush, obs_after_ready); else n_pass++;
    do_instr(2'b00, 4'h0, 16'h0, 1'b0, 0); model_step(2'b00, 16'h0, 1'b0);
    n_checks++; if (obs_pc !== 16'h0abd) $display("FAIL stall_next: got %h exp 0abd", obs_pc); else n_pass++;
  endtask

  task automatic test_reset_mid_eval();
    int w = 0;
    while (!instr_ready && w < 20) begin @(negedge clk); w++; end
    instr_valid = 1'b1; op = 2'b10; cond = 4'h0; target = 16'h3333; fetch_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++; if (pc !== RST_PC || pc_valid !== 1'b0 || instr_ready !== 1'b1) $display("FAIL mid_reset: got pc %h valid %b ready %b exp %h/0/1", pc, pc_valid, instr_ready, RST_PC); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_reset();
    do_instr(2'b11, 4'h0, 16'h0, 1'b0, 0); model_step(2'b11, 16'h0, 1'b0);
    n_checks++; if (obs_pc !== 16'h0000 || obs_flush !== 1'b0 || obs_err !== 1'b1) $display("FAIL mid_reset_ret: got pc %h flush %b err %b exp 0000/0/1", obs_pc, obs_flush, obs_err); else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] o; logic [3:0] c; logic [15:0] t; logic j; int st;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      o = $urandom_range(0, 3); c = $urandom_range(0, 15); t = $urandom;
      j = $urandom_range(0, 1); st = $urandom_range(0, 2);
      do_instr(o, c, t, j, st); model_step(o, t, j);
      n_checks++;
      if (obs_pc !== exp_pc || obs_flush !== exp_flush || obs_err !== exp_err || obs_eval_cond !== c || obs_stall_ok !== 1'b1)
        $display("FAIL rand_%0d op %0d: got pc %h fl %b err %b cc %h st %b exp %h/%b/%b/%h/1", k, o, obs_pc, obs_flush, obs_err, obs_eval_cond, obs_stall_ok, exp_pc, exp_flush, exp_err, c);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_jcc();
    test_call_ret();
    test_ras_overflow();
    test_fetch_stall();
    test_reset_mid_eval();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_controller.md
Name: branch_controller

Overview:
- Sequences the program counter of the 16-bit CPU.
- Accepts one decoded control-flow instruction at a time and drives the condition code into the comparator (CMP) block. It samples CMP's jump result and commits the next PC to fetch over a valid/ready handshake.
- Holds a small circular return-address stack (RAS) for CALL/RET.
- Sits between decode and fetch; CMP stays combinational and is sequenced by this block.

Parameters:
- PC_W, 16, PC and target width.
- RAS_DEPTH, 4, return-stack entries (power of two).
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- instr_valid  in  1  decode presents an instruction.
- instr_ready  out  1  high only in IDLE.
- op  in  2  00 SEQ, 01 JCC, 10 CALL, 11 RET.
- cond  in  4  condition code for JCC; ignored for other ops.
- target  in  PC_W  jump/call destination.
- cmp_cond  out  4  condition code driven to CMP.
- cmp_jump  in  1  CMP result for cmp_cond.
- pc  out  PC_W  current committed PC.
- pc_valid  out  1  new pc offered to fetch.
- fetch_ready  in  1  fetch accepts pc.
- flush  out  1  pc is a redirect (not pc+1); qualifies pc_valid.
- ras_err  out  1  sticky: RAS overflow or underflow occurred.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, pc=RESET_PC, RAS pointer and count=0, ras_err=0.
  - pc_valid=0, flush=0, cmp_cond=4'b0000.
  - Handshakes are ignored while rst_n is low.
  - Reset mid-operation abandons the instruction; no partial stack update.
- FSM IDLE -> EVAL -> COMMIT -> IDLE.
- IDLE:
  - instr_ready=1.
  - On instr_valid&instr_ready at a clock edge: latch op, cond and target; go to EVAL.
- EVAL (exactly 1 cycle):
  - cmp_cond = latched cond, held stable.
  - At the closing edge: sample cmp_jump, compute next PC, update pc, apply the stack operation, go to COMMIT.
- Next PC (all arithmetic modulo 2^PC_W; pc+1 at 16'hFFFF gives 16'h0000):
  - SEQ: pc+1, flush=0.
  - JCC: cmp_jump ? target : pc+1; flush=cmp_jump.
  - CALL: push pc+1, pc=target, flush=1.
  - RET with count>0: pop -> pc, flush=1.
  - RET with count==0: pc=pc+1, flush=0, ras_err<=1.
- RAS push when full:
  - Circular; overwrites the oldest entry; count stays RAS_DEPTH.
  - ras_err<=1.
- RAS pointer wraps modulo RAS_DEPTH.
- ras_err clears only on reset.
- COMMIT:
  - pc_valid=1; flush is held for the whole COMMIT.
  - Stay in COMMIT while fetch_ready=0; pc, flush and cmp_cond are stable.
  - At an edge with fetch_ready=1: go to IDLE; pc_valid and flush drop.
- cmp_cond outside EVAL keeps its last value; CMP output is only sampled in EVAL.
- Undefined codes (4'b0111, 4'b11xx) make CMP return 0, so JCC falls through. No error is raised.
- Latency:
  - Accept edge T0; pc updated at edge T1; pc_valid high in cycle T1..T2.
  - Minimum 3 cycles per instruction.
- instr_valid during EVAL/COMMIT is not accepted; decode holds its inputs.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - op encodings OP_SEQ, OP_JCC, OP_CALL, OP_RET.
  - CMP condition code constants (EQ, NE, GT, LT, ZERO, NEG, ONES, and the N-variants 1000-1011).
  - FSM state enum.
- One sub-module: ras_stack (circular LIFO with push, pop, full, empty and overflow/underflow pulses), instantiated once.

Test Plan:
- Sequential with wrap: reset, then SEQ x2 starting from RESET_PC=16'hFFFF -> pc 16'h0000 then 16'h0001. flush=0 both times; pc_valid 1 cycle each with fetch_ready=1.
- JCC taken and not taken at pc=16'h0010, cond=4'b0000, target=16'h0100:
  - cmp_jump=1 -> pc=16'h0100, flush=1.
  - Repeat with cmp_jump=0 -> pc=16'h0101, flush=0.
  - cmp_cond=4'b0000 throughout EVAL.
- CALL/RET: at pc=16'h0020, CALL target 16'h0200 -> pc=16'h0200. Then RET -> pc=16'h0021, flush=1, ras_err=0.
- RAS overflow/underflow:
  - 5 CALLs from pcs A..E -> ras_err=1.
  - 4 RETs return E+1, D+1, C+1, B+1.
  - A 5th RET -> pc+1, flush=0.
- Fetch stall: hold fetch_ready=0 for 4 cycles during COMMIT -> pc, flush and pc_valid stable, instr_ready=0. Release -> IDLE next cycle, next instruction accepted.
- Reset mid-EVAL after CALL accept -> pc=RESET_PC, RAS empty, pc_valid=0, and a following RET sets ras_err.
